datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath_pkg.sv | 16 +
 rtl/datapath_ram.sv | 31 +++
 rtl/datapath.sv | 96 +++++++++
 tb/tb_datapath.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the accumulator datapath: default widths and the
// encoding of the accumulator source select.
package datapath_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  // Accumulator source select encodings.
  typedef enum logic [1:0] {
    ASEL_ALU  = 2'd0,
    ASEL_IN   = 2'd1,
    ASEL_MEM  = 2'd2,
    ASEL_ZERO = 2'd3
  } asel_e;

endpackage : datapath_pkg

// File: rtl/datapath_ram.sv
// Word-wide memory with combinational read and rising-edge write.
module datapath_ram
  import datapath_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Synchronous write of the addressed word.
  // NOTE: the array has no reset branch on purpose; contents survive reset and
  // a reset loop over every word would block RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read is asynchronous, so data follows the address within the same cycle.
  assign rdata = mem[addr];

endmodule : datapath_ram

// File: rtl/datapath.sv
// Accumulator datapath: accumulator A, instruction register, program counter,
// add/subtract ALU and a small word memory. All sequencing comes from the
// external control inputs.
module datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              PCload,
  input  logic              JMPmux,
  input  logic              IRload,
  input  logic              Meminst,
  input  logic              MemWr,
  input  logic              Aload,
  input  logic              Sub,
  input  logic [1:0]        Asel,
  input  logic [DATA_W-1:0] data_in,
  output logic              Aeq0,
  output logic              Apos,
  output logic [2:0]        IR,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] ir_q;
  logic [ADDR_W-1:0] pc_q;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] a_next;
  logic [ADDR_W-1:0] pc_next;
  logic              mem_we;

  // Address comes either from the IR operand field or the program counter.
  assign mem_addr = Meminst ? ir_q[ADDR_W-1:0] : pc_q;

  // Writes are suppressed during reset so memory is left untouched.
  assign mem_we = MemWr & ~Reset;

  datapath_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (Clock),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(a_q),
    .rdata(mem_rdata)
  );

  // ALU: modular add or subtract, no carry out.
  assign alu_result = Sub ? (a_q - mem_rdata) : (a_q + mem_rdata);

  // Accumulator source mux.
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves a_next
    // unassigned, which would infer a latch.
    a_next = '0;
    case (asel_e'(Asel))
      ASEL_ALU:  a_next = alu_result;
      ASEL_IN:   a_next = data_in;
      ASEL_MEM:  a_next = mem_rdata;
      ASEL_ZERO: a_next = '0;
      default:   a_next = '0;
    endcase
  end

  // Next PC: jump target from IR operand field, or increment with wrap.
  assign pc_next = JMPmux ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);

  // Register file update; reset overrides every load enable.
  always_ff @(posedge Clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // e.g. the memory write sees the old A while A itself is being loaded.
    if (Reset) begin
      a_q  <= '0;
      ir_q <= '0;
      pc_q <= '0;
    end else begin
      if (Aload)  a_q  <= a_next;
      if (IRload) ir_q <= mem_rdata;
      if (PCload) pc_q <= pc_next;
    end
  end

  // Status and data outputs decoded straight from the registers.
  assign Aeq0     = (a_q == '0);
  assign Apos     = ~a_q[DATA_W-1];
  assign IR       = ir_q[DATA_W-1 -: 3];
  assign data_out = a_q;

endmodule : datapath

// File: tb/tb_datapath.sv
// Directed self-checking bench for the accumulator datapath.
module tb_datapath;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub;
  logic [1:0] Asel;
  logic [7:0] data_in;
  logic       Aeq0, Apos;
  logic [2:0] IR;
  logic [7:0] data_out;

  int total = 0;
  int bad   = 0;

  datapath dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .PCload  (PCload),
    .JMPmux  (JMPmux),
    .IRload  (IRload),
    .Meminst (Meminst),
    .MemWr   (MemWr),
    .Aload   (Aload),
    .Sub     (Sub),
    .Asel    (Asel),
    .data_in (data_in),
    .Aeq0    (Aeq0),
    .Apos    (Apos),
    .IR      (IR),
    .data_out(data_out)
  );

  always #5 Clock = ~Clock;

  task automatic idle();
    Reset = 0; PCload = 0; JMPmux = 0; IRload = 0; Meminst = 0;
    MemWr = 0; Aload = 0; Sub = 0; Asel = 2'd0; data_in = 8'h00;
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_a(input logic [7:0] v);
    idle();
    data_in = v; Asel = 2'd1; Aload = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    Reset = 1;
    tick();
    idle();
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_a got=%h want=00", data_out); end
    total++; if (Aeq0 !== 1'b1) begin bad++; $display("FAIL reset_aeq0 got=%b want=1", Aeq0); end
    total++; if (Apos !== 1'b1) begin bad++; $display("FAIL reset_apos got=%b want=1", Apos); end
    total++; if (IR !== 3'b000) begin bad++; $display("FAIL reset_ir got=%b want=000", IR); end
    total++; if (dut.pc_q !== 5'd0) begin bad++; $display("FAIL reset_pc got=%0d want=0", dut.pc_q); end
  endtask

  task automatic test_load_in();
    load_a(8'd5);
    total++; if (data_out !== 8'd5) begin bad++; $display("FAIL load_in_a got=%0d want=5", data_out); end
    total++; if (Aeq0 !== 1'b0) begin bad++; $display("FAIL load_in_aeq0 got=%b want=0", Aeq0); end
    total++; if (Apos !== 1'b1) begin bad++; $display("FAIL load_in_apos got=%b want=1", Apos); end
  endtask

  task automatic test_alu();
    logic [7:0] exp_a [4];
    exp_a[0] = 8'd10; exp_a[1] = 8'd15; exp_a[2] = 8'd10; exp_a[3] = 8'd5;
    // mem[0] <= 5 (PC=0)
    idle(); MemWr = 1; tick(); idle();
    for (int i = 0; i < 4; i++) begin
      Asel = 2'd0; Aload = 1; Sub = (i >= 2);
      tick();
      total++;
      if (data_out !== exp_a[i]) begin
        bad++; $display("FAIL alu_step%0d got=%0d want=%0d", i, data_out, exp_a[i]);
      end
    end
    idle();
  endtask

  task automatic test_ir_mem();
    idle(); IRload = 1; tick(); idle();
    total++; if (dut.ir_q !== 8'h05) begin bad++; $display("FAIL ir_load got=%h want=05", dut.ir_q); end
    total++; if (IR !== 3'b000) begin bad++; $display("FAIL ir_opcode got=%b want=000", IR); end
    load_a(8'd3);
    Meminst = 1; MemWr = 1; tick(); idle();   // mem[5] <= 3
    load_a(8'd0);
    total++; if (Aeq0 !== 1'b1) begin bad++; $display("FAIL ir_zero_aeq0 got=%b want=1", Aeq0); end
    Meminst = 1; Asel = 2'd2; Aload = 1; tick(); idle();
    total++; if (data_out !== 8'd3) begin bad++; $display("FAIL ir_mem_read got=%0d want=3", data_out); end
  endtask

  task automatic test_pc();
    PCload = 1; JMPmux = 1; tick(); idle();
    total++; if (dut.pc_q !== 5'd5) begin bad++; $display("FAIL pc_jump got=%0d want=5", dut.pc_q); end
    PCload = 1; tick(); idle();
    total++; if (dut.pc_q !== 5'd6) begin bad++; $display("FAIL pc_inc got=%0d want=6", dut.pc_q); end
    load_a(8'd1);
    MemWr = 1; tick(); idle();                // mem[6] <= 1
    load_a(8'd0);
    Asel = 2'd2; Aload = 1; tick(); idle();
    total++; if (data_out !== 8'd1) begin bad++; $display("FAIL pc_mem_read got=%0d want=1", data_out); end
    // Put 8'h1F in mem[6], load it into IR, jump to 31, then increment.
    load_a(8'h1F);
    MemWr = 1; tick(); idle();
    IRload = 1; tick(); idle();
    PCload = 1; JMPmux = 1; tick(); idle();
    total++; if (dut.pc_q !== 5'd31) begin bad++; $display("FAIL pc_jump31 got=%0d want=31", dut.pc_q); end
    PCload = 1; tick(); idle();
    total++; if (dut.pc_q !== 5'd0) begin bad++; $display("FAIL pc_wrap got=%0d want=0", dut.pc_q); end
  endtask

  task automatic test_wrap();
    load_a(8'd200);
    total++; if (Apos !== 1'b0) begin bad++; $display("FAIL wrap_apos200 got=%b want=0", Apos); end
    load_a(8'd10);
    MemWr = 1; tick(); idle();                // mem[0] <= 10
    load_a(8'd250);
    Asel = 2'd0; Aload = 1; tick(); idle();
    total++; if (data_out !== 8'd4) begin bad++; $display("FAIL wrap_add got=%0d want=4", data_out); end
    load_a(8'd5);
    MemWr = 1; tick(); idle();                // mem[0] <= 5
    load_a(8'd3);
    Asel = 2'd0; Sub = 1; Aload = 1; tick(); idle();
    total++; if (data_out !== 8'hFE) begin bad++; $display("FAIL wrap_sub got=%h want=fe", data_out); end
    total++; if (Apos !== 1'b0) begin bad++; $display("FAIL wrap_sub_apos got=%b want=0", Apos); end
  endtask

  task automatic test_same_addr();
    load_a(8'h77);
    MemWr = 1; IRload = 1; Aload = 1; Asel = 2'd2; tick(); idle();
    total++; if (dut.ir_q !== 8'h05) begin bad++; $display("FAIL same_addr_ir got=%h want=05", dut.ir_q); end
    total++; if (data_out !== 8'h05) begin bad++; $display("FAIL same_addr_a got=%h want=05", data_out); end
    Asel = 2'd2; Aload = 1; tick(); idle();
    total++; if (data_out !== 8'h77) begin bad++; $display("FAIL same_addr_mem got=%h want=77", data_out); end
  endtask

  task automatic test_reset_mid();
    // IR=05 so jump to PC=5; mem[5] holds 3, mem[0] holds 77.
    PCload = 1; JMPmux = 1; tick(); idle();
    Reset = 1; Aload = 1; Asel = 2'd1; data_in = 8'h55; PCload = 1;
    IRload = 1; MemWr = 1;
    tick(); idle();
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_mid_a got=%h want=00", data_out); end
    total++; if (dut.pc_q !== 5'd0) begin bad++; $display("FAIL rst_mid_pc got=%0d want=0", dut.pc_q); end
    total++; if (dut.ir_q !== 8'h00) begin bad++; $display("FAIL rst_mid_ir got=%h want=00", dut.ir_q); end
    Asel = 2'd2; Aload = 1; tick(); idle();
    total++; if (data_out !== 8'h77) begin bad++; $display("FAIL rst_mid_mem0 got=%h want=77", data_out); end
    for (int i = 0; i < 5; i++) begin
      PCload = 1; tick(); idle();
    end
    Asel = 2'd2; Aload = 1; tick(); idle();
    total++; if (data_out !== 8'h03) begin bad++; $display("FAIL rst_mid_mem5 got=%h want=03", data_out); end
  endtask

  initial begin
    idle();
    @(negedge Clock);
    test_reset();
    test_load_in();
    test_alu();
    test_ir_mem();
    test_pc();
    test_wrap();
    test_same_addr();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_datapath
